// File: rtl/shift_seq32_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: FSM states and op codes.
package shift_seq32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

endpackage

// File: rtl/shift_seq32_shift1_32.sv
// Single-bit shift stage: one position of SLL/SRL/SRA/ROR per evaluation.
module shift1_32
  import shift_seq32_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [1:0]  op_r,
  output logic [31:0] acc_sh
);

  // Select the fill bit and direction for the latched operation.
  always_comb begin
    acc_sh = acc;
    case (op_r)
      SH_SLL:  acc_sh = {acc[30:0], 1'b0};
      SH_SRL:  acc_sh = {1'b0, acc[31:1]};
      SH_SRA:  acc_sh = {acc[31], acc[31:1]};
      SH_ROR:  acc_sh = {acc[0], acc[31:1]};
      default: acc_sh = acc;
    endcase
  end

endmodule

// File: rtl/shift_seq32.sv
// Multi-cycle 32-bit shifter: one bit position per clock, one-cycle done pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; abort wins over start
// ST_SHIFT | one 1-bit shift per edge, cnt counts down to 1
// ST_DONE  | done=1, res already holds the result; back to IDLE next
module shift_seq32
  import shift_seq32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [4:0]  shift,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] res
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] acc;
  logic [31:0] acc_sh;
  logic [4:0]  cnt;
  logic [1:0]  op_r;
  logic        accept;

  shift1_32 u_shift1 (
    .acc    (acc),
    .op_r   (op_r),
    .acc_sh (acc_sh)
  );

  // Outputs decode from the state register only, so no input reaches them.
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = (shift != 5'd0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (abort)              state_nxt = ST_IDLE;
        else if (cnt == 5'd1)   state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch on accept, shift and count down in SHIFT, load res entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      op_r <= '0;
      res  <= '0;
    end else begin
      if (accept) begin
        acc  <= A;
        cnt  <= shift;
        op_r <= op;
      end else if (state == ST_SHIFT && !abort) begin
        acc <= acc_sh;
        cnt <= cnt - 5'd1;
      end
      // A zero-length op goes straight from IDLE to DONE, so res takes A directly.
      if (state_nxt == ST_DONE) begin
        res <= (state == ST_IDLE) ? A : acc_sh;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq32.sv
// Scoreboard bench for shift_seq32: driver pushes expected result and done cycle,
// monitor pops and compares on every done pulse.
module tb_shift_seq32;
  import shift_seq32_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [4:0]  s;
    logic [31:0] r;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] A     = 32'h0;
  logic [4:0]  shift = 5'd0;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc = 32'h0;
  exp_t        q[$];
  logic [31:0] last_res = 32'h0;
  logic        prev_done = 1'b0;

  shift_seq32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .shift (shift),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a,
                                            input logic [4:0] s);
    logic [31:0] r;
    case (o)
      SH_SLL:  r = a << s;
      SH_SRL:  r = a >> s;
      SH_SRA:  r = $signed(a) >>> s;
      default: r = (a >> s) | (a << (6'd32 - {1'b0, s}));
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      check("done_gap", {31'b0, prev_done}, 32'h0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got res %h want no done pulse", res);
      end else begin
        e = q.pop_front();
        check("res", res, e.res);
        check("done_cycle", cyc, e.cyc);
      end
    end
    prev_done = rst_n & done;
  end

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got busy=1 want busy=0 within 40 cycles");
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                       input logic [31:0] exp_res);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    shift = s;
    @(posedge clk);
    #1;
    q.push_back('{res: exp_res, cyc: cyc + {27'b0, s}});
    last_res = exp_res;
    check("busy_after_accept", {31'b0, busy}, 32'h1);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    vec_t        vecs[9];
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [4:0]  rs;

    vecs[0] = '{SH_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000};
    vecs[1] = '{SH_SRA, 32'hF000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[2] = '{SH_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[3] = '{SH_ROR, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[4] = '{SH_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456};
    vecs[5] = '{SH_SLL, 32'h0000_00FF, 5'd4,  32'h0000_0FF0};
    vecs[6] = '{SH_SRA, 32'h7000_0000, 5'd1,  32'h3800_0000};
    vecs[7] = '{SH_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000};
    vecs[8] = '{SH_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_res",  res, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    foreach (vecs[i]) do_op(vecs[i].o, vecs[i].a, vecs[i].s, vecs[i].r);

    // start held high: accepts at edges 0, 5, 10 only (period shift+2 = 5).
    @(negedge clk);
    op    = SH_SLL;
    shift = 5'd3;
    start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      A = 32'h0000_0100 + i;
      @(posedge clk);
      #1;
      if (i == 0)  begin q.push_back('{res: 32'h0000_0800, cyc: cyc + 32'd3}); last_res = 32'h0000_0800; end
      if (i == 5)  begin q.push_back('{res: 32'h0000_0828, cyc: cyc + 32'd3}); last_res = 32'h0000_0828; end
      if (i == 10) begin q.push_back('{res: 32'h0000_0850, cyc: cyc + 32'd3}); last_res = 32'h0000_0850; end
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // abort sampled at E2 of a shift=10 op: no done, res unchanged.
    @(negedge clk);
    start = 1'b1;
    op    = SH_SLL;
    A     = 32'hDEAD_BEEF;
    shift = 5'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort_busy_e0", {31'b0, busy}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_res", res, last_res);
    repeat (12) @(negedge clk);
    check("abort_res_hold", res, last_res);

    // abort beats start in IDLE.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    A     = 32'h5555_AAAA;
    shift = 5'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    check("idle_abort_res", res, last_res);

    // Randomized ops against the shift-operator model.
    for (int n = 0; n < 1000; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rs = 5'($urandom_range(0, 31));
      do_op(ro, ra, rs, ref_shift(ro, ra, rs));
    end

    // Reset mid-shift clears everything asynchronously, with no done pulse.
    @(negedge clk);
    start = 1'b1;
    op    = SH_SRA;
    A     = 32'h8000_0000;
    shift = 5'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_res",  res, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("midrst_res_hold", res, 32'h0);

    check("queue_drained", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
